// File: rtl/pong_match_sequencer.sv
// Match-level Pong controller: STARTUP/SERVE/PLAY/POINT/OVER phases, scores, ball arming.
// All outputs are registered (1 cycle after trigger); optional serve blink via PONG_SERVE_BLINK_EN.
module pong_match_sequencer #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       key_any,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       game_startup,
  output logic       game_over,
  output logic       sq_shown,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       play_en,
  output logic       ball_reset,
  output logic       serve_dir
);

  typedef enum logic [2:0] {S_STARTUP, S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

  localparam logic [7:0] SERVE_N = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_N = 8'(POINT_FRAMES);
  localparam logic [3:0] WIN_N   = 4'(WIN_SCORE);

  state_t     state, state_nxt;
  logic       key_q;
  logic       key_press;
  logic       serve_entry;
  logic [7:0] frame_cnt, frame_cnt_nxt;
  logic [3:0] p1_nxt, p2_nxt;
  logic       dir_nxt, br_nxt, sq_nxt;
  logic       blink_flip;

  assign key_press = key_any & ~key_q;

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    p1_nxt        = score_p1;
    p2_nxt        = score_p2;
    dir_nxt       = serve_dir;
    br_nxt        = 1'b0;
    serve_entry   = 1'b0;
    case (state)
      S_STARTUP: begin
        if (key_press) begin
          p1_nxt        = 4'd0;
          p2_nxt        = 4'd0;
          dir_nxt       = 1'b0;
          br_nxt        = 1'b1;
          frame_cnt_nxt = 8'd0;
          serve_entry   = 1'b1;
          state_nxt     = S_SERVE;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          frame_cnt_nxt = frame_cnt + 8'd1;
          if (frame_cnt_nxt == SERVE_N) state_nxt = S_PLAY;
        end
      end
      S_PLAY: begin
        // miss_right has priority when both misses land together
        if (miss_right) begin
          p1_nxt        = score_p1 + 4'd1;
          dir_nxt       = 1'b1;
          frame_cnt_nxt = 8'd0;
          state_nxt     = S_POINT;
        end else if (miss_left) begin
          p2_nxt        = score_p2 + 4'd1;
          dir_nxt       = 1'b0;
          frame_cnt_nxt = 8'd0;
          state_nxt     = S_POINT;
        end
      end
      S_POINT: begin
        if (frame_tick) begin
          frame_cnt_nxt = frame_cnt + 8'd1;
          if (frame_cnt_nxt == POINT_N) begin
            if (score_p1 == WIN_N || score_p2 == WIN_N) begin
              state_nxt = S_OVER;
            end else begin
              br_nxt        = 1'b1;
              frame_cnt_nxt = 8'd0;
              serve_entry   = 1'b1;
              state_nxt     = S_SERVE;
            end
          end
        end
      end
      S_OVER: begin
        if (key_press) state_nxt = S_STARTUP;
      end
      default: state_nxt = S_STARTUP;
    endcase

    sq_nxt = (state_nxt == S_SERVE) || (state_nxt == S_PLAY);
    if (state_nxt == S_SERVE && !serve_entry) sq_nxt = sq_shown ^ blink_flip;
  end

`ifdef PONG_SERVE_BLINK_EN
  localparam logic [7:0] BLINK_N = 8'(BLINK_FRAMES);
  logic [7:0] blink_cnt, blink_cnt_nxt;

  always_comb begin
    blink_cnt_nxt = blink_cnt;
    blink_flip    = 1'b0;
    if (serve_entry) begin
      blink_cnt_nxt = 8'd0;
    end else if (state == S_SERVE && frame_tick) begin
      blink_cnt_nxt = blink_cnt + 8'd1;
      if (blink_cnt_nxt == BLINK_N) begin
        blink_cnt_nxt = 8'd0;
        blink_flip    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_0) begin
    if (!rst) blink_cnt <= 8'd0;
    else      blink_cnt <= blink_cnt_nxt;
  end
`else
  assign blink_flip = 1'b0;
`endif

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      state        <= S_STARTUP;
      key_q        <= 1'b1;
      frame_cnt    <= 8'd0;
      score_p1     <= 4'd0;
      score_p2     <= 4'd0;
      serve_dir    <= 1'b0;
      ball_reset   <= 1'b0;
      sq_shown     <= 1'b0;
      play_en      <= 1'b0;
      game_startup <= 1'b1;
      game_over    <= 1'b0;
    end else begin
      state        <= state_nxt;
      key_q        <= key_any;
      frame_cnt    <= frame_cnt_nxt;
      score_p1     <= p1_nxt;
      score_p2     <= p2_nxt;
      serve_dir    <= dir_nxt;
      ball_reset   <= br_nxt;
      sq_shown     <= sq_nxt;
      play_en      <= (state_nxt == S_PLAY);
      game_startup <= (state_nxt == S_STARTUP);
      game_over    <= (state_nxt == S_OVER);
    end
  end

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Bench for pong_match_sequencer: vector table, directed match sequences, randomized run vs phase model.
module tb_pong_match_sequencer;

  localparam int WIN = 11, SERVE_N = 60, POINT_N = 30, BLINK_N = 8;
`ifdef PONG_SERVE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic clk_0 = 1'b0, rst = 1'b0, frame_tick = 1'b0, key_any = 1'b1;
  logic miss_left = 1'b0, miss_right = 1'b0;
  logic game_startup, game_over, sq_shown, play_en, ball_reset, serve_dir;
  logic [3:0] score_p1, score_p2;

  int checks = 0, errors = 0;

  pong_match_sequencer #(.WIN_SCORE(WIN), .SERVE_FRAMES(SERVE_N),
                         .POINT_FRAMES(POINT_N), .BLINK_FRAMES(BLINK_N)) dut (
    .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick), .key_any(key_any),
    .miss_left(miss_left), .miss_right(miss_right), .game_startup(game_startup),
    .game_over(game_over), .sq_shown(sq_shown), .score_p1(score_p1), .score_p2(score_p2),
    .play_en(play_en), .ball_reset(ball_reset), .serve_dir(serve_dir));

  always #20 clk_0 = ~clk_0;

  // Phase-level model: counts elapsed ticks per phase, outputs derived from the phase name.
  localparam int PH_START = 0, PH_SERVE = 1, PH_PLAY = 2, PH_POINT = 3, PH_OVER = 4;
  int m_phase, m_p1, m_p2, m_sticks, m_pticks;
  bit m_dir, m_br, m_keyprev;

  function automatic bit m_show();
    if (m_phase == PH_SERVE) return BLINK ? ((m_sticks / BLINK_N) % 2 == 0) : 1'b1;
    return m_phase == PH_PLAY;
  endfunction

  task automatic model_step(input bit r, ft, ka, ml, mr);
    bit press;
    if (!r) begin
      m_phase = PH_START; m_p1 = 0; m_p2 = 0; m_sticks = 0; m_pticks = 0;
      m_dir = 0; m_br = 0; m_keyprev = 1;
      return;
    end
    press = ka && !m_keyprev;
    m_keyprev = ka;
    m_br = 0;
    case (m_phase)
      PH_START: if (press) begin
        m_p1 = 0; m_p2 = 0; m_dir = 0;
        m_phase = PH_SERVE; m_sticks = 0; m_br = 1;
      end
      PH_SERVE: if (ft) begin
        m_sticks++;
        if (m_sticks == SERVE_N) m_phase = PH_PLAY;
      end
      PH_PLAY: if (mr || ml) begin
        if (mr) begin m_p1++; m_dir = 1; end
        else    begin m_p2++; m_dir = 0; end
        m_phase = PH_POINT; m_pticks = 0;
      end
      PH_POINT: if (ft) begin
        m_pticks++;
        if (m_pticks == POINT_N) begin
          if (m_p1 == WIN || m_p2 == WIN) m_phase = PH_OVER;
          else begin m_phase = PH_SERVE; m_sticks = 0; m_br = 1; end
        end
      end
      default: if (press) m_phase = PH_START;
    endcase
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model.game_startup", int'(game_startup), int'(m_phase == PH_START));
    chk("model.game_over",    int'(game_over),    int'(m_phase == PH_OVER));
    chk("model.play_en",      int'(play_en),      int'(m_phase == PH_PLAY));
    chk("model.sq_shown",     int'(sq_shown),     int'(m_show()));
    chk("model.ball_reset",   int'(ball_reset),   int'(m_br));
    chk("model.score_p1",     int'(score_p1),     m_p1);
    chk("model.score_p2",     int'(score_p2),     m_p2);
    chk("model.serve_dir",    int'(serve_dir),    int'(m_dir));
  endtask

  // One clock: drive inputs after a falling edge, sample outputs at the next falling edge.
  task automatic cyc(input bit r, ft, ka, ml, mr);
    rst = r; frame_tick = ft; key_any = ka; miss_left = ml; miss_right = mr;
    model_step(r, ft, ka, ml, mr);
    @(posedge clk_0);
    @(negedge clk_0);
    cmp_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0);
  endtask

  typedef struct {
    bit r, ft, ka, ml, mr;
    bit st, ov, sq, pe, br;
    int p1, p2;
    bit dir;
  } vec_t;
  vec_t tbl[8];

  initial begin
    //           r  ft ka ml mr   st ov sq pe br  p1 p2 dir
    tbl[0] = '{0, 0, 1, 0, 0,   1, 0, 0, 0, 0,  0, 0, 0};
    tbl[1] = '{0, 1, 1, 0, 0,   1, 0, 0, 0, 0,  0, 0, 0};
    tbl[2] = '{1, 0, 1, 0, 0,   1, 0, 0, 0, 0,  0, 0, 0};
    tbl[3] = '{1, 1, 1, 0, 1,   1, 0, 0, 0, 0,  0, 0, 0};
    tbl[4] = '{1, 0, 0, 0, 0,   1, 0, 0, 0, 0,  0, 0, 0};
    tbl[5] = '{1, 1, 1, 0, 0,   0, 0, 1, 0, 1,  0, 0, 0};
    tbl[6] = '{1, 0, 1, 0, 0,   0, 0, 1, 0, 0,  0, 0, 0};
    tbl[7] = '{1, 0, 0, 1, 1,   0, 0, 1, 0, 0,  0, 0, 0};

    @(negedge clk_0);
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].r, tbl[i].ft, tbl[i].ka, tbl[i].ml, tbl[i].mr);
      chk($sformatf("vec%0d.game_startup", i), int'(game_startup), int'(tbl[i].st));
      chk($sformatf("vec%0d.game_over", i),    int'(game_over),    int'(tbl[i].ov));
      chk($sformatf("vec%0d.sq_shown", i),     int'(sq_shown),     int'(tbl[i].sq));
      chk($sformatf("vec%0d.play_en", i),      int'(play_en),      int'(tbl[i].pe));
      chk($sformatf("vec%0d.ball_reset", i),   int'(ball_reset),   int'(tbl[i].br));
      chk($sformatf("vec%0d.score_p1", i),     int'(score_p1),     tbl[i].p1);
      chk($sformatf("vec%0d.score_p2", i),     int'(score_p2),     tbl[i].p2);
      chk($sformatf("vec%0d.serve_dir", i),    int'(serve_dir),    int'(tbl[i].dir));
    end

    // Serve timing and blink pattern
    for (int i = 1; i < SERVE_N; i++) begin
      cyc(1, 1, 0, 0, 0);
      chk("serve.no_play", int'(play_en), 0);
      chk("serve.sq", int'(sq_shown), BLINK ? int'((i / BLINK_N) % 2 == 0) : 1);
    end
    cyc(1, 1, 0, 0, 0);
    chk("serve.play_after_last", int'(play_en), 1);

    // Right miss -> player 1 scores, point phase, then re-serve
    cyc(1, 0, 0, 0, 1);
    chk("miss_r.p1", int'(score_p1), 1);
    chk("miss_r.dir", int'(serve_dir), 1);
    chk("miss_r.play_en", int'(play_en), 0);
    ticks(POINT_N - 1);
    chk("point.no_early_reset", int'(ball_reset), 0);
    cyc(1, 1, 0, 0, 0);
    chk("point.ball_reset", int'(ball_reset), 1);
    chk("point.serve_sq", int'(sq_shown), 1);
    cyc(1, 0, 0, 0, 0);
    chk("point.ball_reset_once", int'(ball_reset), 0);

    // Simultaneous misses: right wins
    ticks(SERVE_N);
    cyc(1, 0, 0, 1, 1);
    chk("both.p1", int'(score_p1), 2);
    chk("both.p2", int'(score_p2), 0);
    ticks(POINT_N);

    // Player 2 wins the match; miss coincides with tick each time
    for (int k = 0; k < WIN; k++) begin
      ticks(SERVE_N);
      cyc(1, 1, 0, 1, 0);
      ticks(POINT_N);
    end
    chk("over.game_over", int'(game_over), 1);
    chk("over.p2", int'(score_p2), WIN);
    cyc(1, 0, 0, 0, 1);
    chk("over.miss_ignored_p1", int'(score_p1), 2);
    chk("over.still_over", int'(game_over), 1);
    cyc(1, 0, 1, 0, 0);
    chk("over.to_startup", int'(game_startup), 1);
    chk("over.scores_kept", int'(score_p2), WIN);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("restart.p2_cleared", int'(score_p2), 0);
    chk("restart.ball_reset", int'(ball_reset), 1);
    ticks(5);
    cyc(0, 1, 0, 0, 0);
    chk("midreset.startup", int'(game_startup), 1);
    chk("midreset.sq", int'(sq_shown), 0);

    // Randomized play against the model
    begin
      bit ka = 0;
      for (int n = 0; n < 20000; n++) begin
        if ($urandom_range(0, 39) == 0) ka = ~ka;
        cyc($urandom_range(0, 2999) != 0, 1'($urandom_range(0, 1)), ka,
            $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_match_sequencer.md
# pong_match_sequencer

Match-level controller for the Pong engine. It steps the game through startup, serve, rally, point and game-over phases, keeps both scores, and arms and disarms the ball physics. It drives the game-state and score inputs of the pixel renderer and the enable/reset inputs of the ball/paddle motion logic. All timing is counted in video frames, so phase durations do not depend on the pixel clock.

## Interface
Parameters:
- WIN_SCORE, 11: score that ends the match; must be ≤ 11 (renderer digit range).
- SERVE_FRAMES, 60: frames spent in SERVE before the ball is released; 1..255.
- POINT_FRAMES, 30: frames spent in POINT after a miss; 1..255.
- BLINK_FRAMES, 8: frames per ball blink half-period during SERVE; 1..255.

Ports:
- clk_0  in  1  25.175 MHz pixel clock.
- rst  in  1  reset; synchronous, active-low.
- frame_tick  in  1  one-cycle pulse per frame, from the sync generator at the start of vertical blank.
- key_any  in  1  level; high while any debounced player key is pressed.
- miss_left  in  1  one-cycle pulse; the ball left the field past paddle 1, so player 2 scores.
- miss_right  in  1  one-cycle pulse; the ball left the field past paddle 2, so player 1 scores.
- game_startup  out  1  high in STARTUP.
- game_over  out  1  high in OVER.
- sq_shown  out  1  ball visibility.
- score_p1  out  4  player 1 score.
- score_p2  out  4  player 2 score.
- play_en  out  1  high in PLAY; gates ball and paddle motion.
- ball_reset  out  1  one-cycle pulse; re-centre the ball.
- serve_dir  out  1  launch direction: 0 = toward paddle 1 (left), 1 = toward paddle 2 (right).

## Operation
- States: STARTUP, SERVE, PLAY, POINT, OVER. Reset enters STARTUP.
- key_press is the rising edge of key_any, taken from a 1-cycle registered copy. A held key never re-triggers.
- **STARTUP**
  - game_startup=1; sq_shown=0; play_en=0.
  - On key_press: clear both scores, set serve_dir=0, pulse ball_reset, clear frame_cnt, go to SERVE.
- **SERVE**
  - play_en=0.
  - frame_cnt (8-bit) increments on each frame_tick.
  - On the tick that makes frame_cnt == SERVE_FRAMES, go to PLAY.
- **PLAY**
  - play_en=1; sq_shown=1.
  - miss_right: score_p1 += 1; serve_dir=1.
  - miss_left: score_p2 += 1; serve_dir=0.
  - After either miss: clear frame_cnt and go to POINT.
  - If both misses arrive in the same cycle, miss_right wins and miss_left is dropped.
- **POINT**
  - play_en=0; sq_shown=0.
  - Count frame_ticks. On the tick that makes frame_cnt == POINT_FRAMES:
    - if score_p1 == WIN_SCORE or score_p2 == WIN_SCORE, go to OVER;
    - otherwise pulse ball_reset, clear frame_cnt, go to SERVE.
- **OVER**
  - game_over=1; sq_shown=0; play_en=0; scores held.
  - On key_press: go to STARTUP. Scores stay visible until the next start.
- Scores change only in PLAY, so they never exceed WIN_SCORE.
- miss_left and miss_right are ignored outside PLAY. key_press is ignored in SERVE, PLAY and POINT.

## Timing
- All outputs are registered. A state change and its output values appear 1 cycle after the triggering input.
- ball_reset is high for exactly the first cycle in which the state register reads SERVE.
- A score update is visible in the same cycle the state first reads POINT.
- Reset values:
  - state=STARTUP; game_startup=1.
  - game_over=0; sq_shown=0; play_en=0; ball_reset=0; serve_dir=0.
  - score_p1=0; score_p2=0; frame_cnt=0; blink_cnt=0; key_any registered copy=1 (so a key held through reset is not a press).
- Reset mid-match: everything returns to the reset values on the next edge. Pending pulses are discarded.
- If frame_tick and key_press coincide in STARTUP or OVER, key_press is acted on.
- If frame_tick coincides with a miss in PLAY, the miss is acted on.

## Configuration
- PONG_SERVE_BLINK_EN defined:
  - In SERVE, sq_shown starts at 1 on SERVE entry and toggles every BLINK_FRAMES frame_ticks, using an 8-bit blink_cnt that clears on SERVE entry.
- PONG_SERVE_BLINK_EN undefined:
  - sq_shown=1 for the whole of SERVE.
  - blink_cnt is not built.

## Test plan
- Reset with key_any held high, then release and press again → no exit from STARTUP until the second rising edge; after it, SERVE entry, ball_reset high for 1 cycle, score_p1=score_p2=0.
- In SERVE, apply 60 frame_ticks → play_en rises 1 cycle after the 60th tick; no change after 59 ticks.
- In PLAY, pulse miss_right → score_p1=1, serve_dir=1, state POINT. Then 30 ticks → ball_reset pulse and SERVE entry.
- In PLAY, pulse miss_left and miss_right in the same cycle → score_p1 increments, score_p2 unchanged.
- Drive score_p2 to 11 → after POINT_FRAMES ticks, game_over=1 and scores held. A miss pulse in OVER changes nothing. key_press → STARTUP.
- With PONG_SERVE_BLINK_EN and BLINK_FRAMES=8 → in SERVE, sq_shown reads 1,0,1 across ticks 0–7, 8–15 and 16–23. Without the macro → sq_shown stays 1.
